mult_share_arbiter: RTL

- Round-robin arbiter and sequencer that shares one sequential shift-add multiplier engine among `N` requesters.
- Each transaction runs as: accept a request, latch its operands, launch the engine, wait for completion, then return the `2W`-bit product to the requester that owns it.
- Sits between requesting datapath blocks and the single multiplier instance; exactly one multiplication is in flight at any time.

---
 rtl/mult_share_arbiter.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter/sequencer sharing one sequential multiplier engine among N requesters.
// Optional WAIT watchdog is built only when MULT_ARB_TIMEOUT_EN is defined.
module mult_share_arbiter #(
    parameter int N       = 4,
    parameter int W       = 4,
    parameter int TIMEOUT = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [N-1:0]     req,
    input  logic [N*W-1:0]   req_a,
    input  logic [N*W-1:0]   req_b,
    output logic [N-1:0]     ack,
    output logic [N-1:0]     rsp_valid,
    output logic [2*W-1:0]   rsp_prod,
    output logic             rsp_err,
    output logic             mul_start,
    output logic [W-1:0]     mul_a,
    output logic [W-1:0]     mul_b,
    input  logic             mul_done,
    input  logic [2*W-1:0]   mul_prod,
    output logic [1:0]       o_dbg_state
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [IW-1:0]   r_ptr;
    logic [IW-1:0]   r_owner;
    logic [IW-1:0]   w_win;
    logic [IW-1:0]   w_ptr_nxt;
    logic            w_found;
    logic [W-1:0]    w_sel_a;
    logic [W-1:0]    w_sel_b;
    logic [W-1:0]    r_mul_a;
    logic [W-1:0]    r_mul_b;
    logic [2*W-1:0]  r_result;
    logic            w_timeout;
    logic            w_err;

`ifdef MULT_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0]   r_cnt;
    logic            r_err;
    assign w_timeout = (r_cnt == CW'(TIMEOUT - 1));
    assign w_err     = r_err;
`else
    logic            w_unused;
    assign w_unused  = (TIMEOUT != 0);
    assign w_timeout = 1'b0;
    assign w_err     = 1'b0;
`endif

    // Round-robin search: first set request at ptr, ptr+1, ... mod N.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 0; k < N; k++) begin
            if (!w_found && req[IW'((int'(r_ptr) + k) % N)]) begin
                w_found = 1'b1;
                w_win   = IW'((int'(r_ptr) + k) % N);
            end
        end
    end

    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int i = 0; i < N; i++) begin
            if (w_win == IW'(i)) begin
                w_sel_a = req_a[i*W +: W];
                w_sel_b = req_b[i*W +: W];
            end
        end
    end

    assign w_ptr_nxt = (r_owner == IW'(N - 1)) ? '0 : r_owner + IW'(1);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state  <= S_IDLE;
            r_ptr    <= '0;
            r_owner  <= '0;
            r_mul_a  <= '0;
            r_mul_b  <= '0;
            r_result <= '0;
`ifdef MULT_ARB_TIMEOUT_EN
            r_cnt    <= '0;
            r_err    <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_owner <= w_win;
                        r_mul_a <= w_sel_a;
                        r_mul_b <= w_sel_b;
                    end
                end
                S_ISSUE: begin
                    r_ptr <= w_ptr_nxt;
`ifdef MULT_ARB_TIMEOUT_EN
                    r_cnt <= '0;
`endif
                end
                S_WAIT: begin
                    if (mul_done) begin
                        r_result <= mul_prod;
`ifdef MULT_ARB_TIMEOUT_EN
                        r_err    <= 1'b0;
`endif
                    end
`ifdef MULT_ARB_TIMEOUT_EN
                    // A done arriving on the timeout edge still wins.
                    else if (w_timeout) begin
                        r_result <= '0;
                        r_err    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_found) w_next = S_ISSUE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  if (mul_done || w_timeout) w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        ack       = '0;
        rsp_valid = '0;
        rsp_prod  = '0;
        rsp_err   = 1'b0;
        mul_start = 1'b0;
        case (r_state)
            S_ISSUE: begin
                ack       = N'(1) << r_owner;
                mul_start = 1'b1;
            end
            S_RESP: begin
                rsp_valid = N'(1) << r_owner;
                rsp_prod  = r_result;
                rsp_err   = w_err;
            end
            default: ;
        endcase
    end

    assign mul_a       = r_mul_a;
    assign mul_b       = r_mul_b;
    assign o_dbg_state = r_state;

endmodule
